// File: rtl/gfx_mvp_compose.sv
// Sequencer computing mvp = proj*(view*model) through one shared start/done multiplier.
// Matrices are flat mat4 words: element (r,c) is 32 bits at [(r*4+c)*32 +: 32].
package gfx_defs;
    localparam int MAT4_W = 512;
endpackage

// state     | meaning
// IDLE      | ready for a job
// VM_START  | start pulse for view*model
// VM_WAIT   | wait for vm product
// PVM_START | start pulse for proj*vm
// PVM_WAIT  | wait for mvp product
// OUT       | mvp held until consumer takes it
module gfx_mvp_compose #(
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [gfx_defs::MAT4_W-1:0] proj,
    input  logic [gfx_defs::MAT4_W-1:0] view,
    input  logic [gfx_defs::MAT4_W-1:0] model,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [gfx_defs::MAT4_W-1:0] mvp,
    output logic                        mul_start,
    output logic [gfx_defs::MAT4_W-1:0] mul_a,
    output logic [gfx_defs::MAT4_W-1:0] mul_b,
    input  logic                        mul_done,
    input  logic [gfx_defs::MAT4_W-1:0] mul_q,
    output logic                        err
);
    localparam int W  = gfx_defs::MAT4_W;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE, VM_START, VM_WAIT, PVM_START, PVM_WAIT, OUT
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    proj_r;
    logic [CW-1:0]   cnt;
    logic            waiting;
    logic            timeout_hit;

    assign waiting     = (state == VM_WAIT) || (state == PVM_WAIT);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (in_valid) state_nx = VM_START;
            VM_START:  state_nx = VM_WAIT;
            VM_WAIT: begin
                if (mul_done)         state_nx = PVM_START;
                else if (timeout_hit) state_nx = IDLE;
            end
            PVM_START: state_nx = PVM_WAIT;
            PVM_WAIT: begin
                if (mul_done)         state_nx = OUT;
                else if (timeout_hit) state_nx = IDLE;
            end
            OUT:       if (out_ready) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
        mul_start = (state == VM_START) || (state == PVM_START);
        err       = waiting && timeout_hit && !mul_done;
    end

    // Operands are loaded one edge before each start pulse and only change again after the
    // matching done edge; mul_b doubles as the vm register for the second product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proj_r <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            mvp    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    proj_r <= proj;
                    mul_a  <= view;
                    mul_b  <= model;
                end
                VM_WAIT: if (mul_done) begin
                    mul_a <= proj_r;
                    mul_b <= mul_q;
                end
                PVM_WAIT: if (mul_done) mvp <= mul_q;
                default: ;
            endcase
        end
    end

    // Saturates at CNT_LAST so it never wraps, including the disabled case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (mul_start) begin
            cnt <= '0;
        end else if (waiting && (TIMEOUT != 0) && (cnt != CNT_LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_gfx_mvp_compose.sv
// Directed bench for gfx_mvp_compose: behavioural latency-L multiplier plus an mvp scoreboard.
module tb_gfx_mvp_compose;
    localparam int W  = 512;
    localparam int TO = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] proj = '0, view = '0, model = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] mvp;
    logic         mul_start;
    logic [W-1:0] mul_a, mul_b;
    logic         mul_done;
    logic [W-1:0] mul_q = '0;
    logic         err;

    logic done_m = 1'b0, done_inj = 1'b0;
    assign mul_done = done_m | done_inj;

    gfx_mvp_compose #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .proj(proj), .view(view), .model(model), .out_valid(out_valid),
        .out_ready(out_ready), .mvp(mvp), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_done(mul_done), .mul_q(mul_q), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int pass = 0, total = 0, err_seen = 0;
    logic [W-1:0] sbq[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // diag(s,s,s,w) with element (0,3) = tx
    function automatic logic [W-1:0] mat(input int s, input int w, input int tx);
        logic [W-1:0] m = '0;
        m[0*32 +: 32]  = s;
        m[5*32 +: 32]  = s;
        m[10*32 +: 32] = s;
        m[15*32 +: 32] = w;
        m[3*32 +: 32]  = tx;
        return m;
    endfunction

    function automatic logic [W-1:0] matmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                logic [31:0] acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc + a[(r*4+k)*32 +: 32] * b[(k*4+c)*32 +: 32];
                m[(r*4+c)*32 +: 32] = acc;
            end
        return m;
    endfunction

    // multiplier model: done exactly mlat cycles after the start cycle
    int           mlat = 1;
    bit           msilent = 0;
    int           pend = 0;
    bit           stab = 0, track = 0;
    logic [W-1:0] cap_a, cap_b, prod;

    always @(negedge clk) begin
        done_m = 1'b0;
        if (rst) track = 0;
        if (pend > 0) begin
            if (mul_a !== cap_a || mul_b !== cap_b) stab = 0;
            pend--;
            if (pend == 0) begin
                done_m = 1'b1;
                mul_q  = prod;
                if (track) chk_int("opnd_stable", int'(stab), 1);
            end
        end
        if (mul_start && !msilent) begin
            cap_a = mul_a;
            cap_b = mul_b;
            prod  = matmul(mul_a, mul_b);
            pend  = mlat;
            stab  = 1;
            track = 1;
        end
    end

    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got result %0h expected none", mvp);
            end else begin
                chk("sb_mvp", mvp, sbq.pop_front());
            end
        end
        if (err) err_seen++;
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_hi(input bit use_out, input string name);
        for (int i = 0; i < 200; i++) begin
            if (use_out ? out_valid : mul_start) return;
            nxt();
        end
        total++;
        $display("FAIL %s: got no response in 200 cycles expected one", name);
    endtask

    task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] v, input logic [W-1:0] m,
                           input logic [W-1:0] exp, input int lat, input int hold, input int inj);
        int t0;
        mlat = lat;
        nxt();
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1; proj = p; view = v; model = m;
        t0 = cyc;
        sbq.push_back(exp);
        nxt();
        in_valid = 0; proj = '0; view = '0; model = '0;
        wait_hi(0, "start1");
        chk_int("start1_cyc", cyc, t0 + 1);
        chk("start1_a_view", mul_a, v);
        chk("start1_b_model", mul_b, m);
        nxt();
        wait_hi(0, "start2");
        chk_int("start2_cyc", cyc, t0 + 2 + lat);
        chk("start2_a_proj", mul_a, p);
        nxt();
        wait_hi(1, "out_valid");
        chk_int("out_valid_cyc", cyc, t0 + 3 + 2*lat);
        for (int i = 0; i < hold; i++) begin
            chk("hold_mvp", mvp, exp);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_no_start", mul_start, 0);
            chk("hold_out_valid", out_valid, 1);
            done_inj = (i == inj);
            nxt();
        end
        done_inj = 0;
        out_ready = 1;
        nxt();
        out_ready = 0;
        chk_int("in_ready_cyc", cyc, t0 + 4 + 2*lat + hold);
        chk("after_in_ready", in_ready, 1);
        chk("after_out_valid", out_valid, 0);
    endtask

    initial begin
        int s, e0, t0;
        #2 rst = 1;
        nxt();
        nxt();
        rst = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_err", err, 0);
        chk("rst_mvp", mvp, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);

        run_job(mat(1,1,0), mat(1,1,0), mat(1,1,0), mat(1,1,0), 3, 0, -1);
        run_job(mat(2,1,0), mat(1,1,1), mat(3,1,0), mat(6,1,2), 1, 0, -1);
        run_job(mat(1,1,5), mat(2,1,0), mat(3,1,1), mat(6,1,7), 2, 20, -1);
        run_job(mat(1,1,0), mat(3,1,0), mat(1,1,4), mat(3,1,12), 7, 5, 2);

        // watchdog: multiplier never answers
        msilent = 1;
        nxt();
        e0 = err_seen;
        in_valid = 1; view = mat(1,1,0); model = mat(1,1,0);
        nxt();
        in_valid = 0;
        wait_hi(0, "wd_start");
        s = cyc;
        for (int k = 1; k < TO; k++) begin
            nxt();
            chk("wd_err_low", err, 0);
            chk("wd_no_out", out_valid, 0);
        end
        nxt();
        chk_int("wd_err_cyc", cyc, s + TO);
        chk("wd_err_high", err, 1);
        nxt();
        chk("wd_err_once", err, 0);
        chk("wd_idle", in_ready, 1);
        chk("wd_out_valid", out_valid, 0);
        chk_int("wd_err_count", err_seen, e0 + 1);
        msilent = 0;

        // done arriving on the timeout cycle wins
        e0 = err_seen;
        run_job(mat(2,1,0), mat(1,1,1), mat(3,1,0), mat(6,1,2), TO, 0, -1);
        chk_int("done_wins_no_err", err_seen, e0);

        // async reset in VM_WAIT, late done afterwards
        mlat = 7;
        nxt();
        in_valid = 1; proj = mat(1,1,0); view = mat(1,1,3); model = mat(2,1,0);
        t0 = cyc;
        nxt();
        in_valid = 0;
        nxt();
        nxt();
        rst = 1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_mul_start", mul_start, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_mul_a", mul_a, '0);
        chk("mid_rst_mul_b", mul_b, '0);
        chk("mid_rst_mvp", mvp, '0);
        nxt();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            nxt();
            chk("late_done_idle", in_ready, 1);
            chk("late_done_no_start", mul_start, 0);
        end
        chk_int("late_done_delivered", int'(pend == 0 && cyc > t0 + 8), 1);

        run_job(mat(2,1,0), mat(1,1,1), mat(3,1,0), mat(6,1,2), 1, 0, -1);

        nxt();
        nxt();
        chk_int("sb_drained", sbq.size(), 0);
        chk_int("err_total", err_seen, 1);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/gfx_mvp_compose.md
# gfx_mvp_compose

Initiator-side sequencer for the gfx pipeline's start/done matrix-multiply unit. It accepts one (proj, view, model) job per ready/valid handshake and drives two dependent products through a single external multiplier: first vm = view·model, then mvp = proj·vm. It returns mvp on a ready/valid output. It sits between the transform-setup logic and the shared matrix multiplier, owns all of the multiplier's control, and adds a completion watchdog.

## Interface
- TIMEOUT, 255: maximum cycles from a mul_start pulse to mul_done. 0 disables the watchdog.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted when high together with in_valid.
- proj, view, model  in  mat4  job operands (mat4 as defined in gfx_defs); sampled at acceptance.
- out_valid  out  1  mvp holds a result.
- out_ready  in  1  consumer takes the result.
- mvp  out  mat4  result proj·view·model.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  mat4  multiplier operands; product is mul_a·mul_b.
- mul_done  in  1  one-cycle completion pulse from the multiplier.
- mul_q  in  mat4  multiplier result; valid in the mul_done cycle.
- err  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, VM_START, VM_WAIT, PVM_START, PVM_WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, register proj, view and model, then go to VM_START.
- VM_START:
  - mul_start=1, mul_a=view_r, mul_b=model_r.
  - Go to VM_WAIT.
- VM_WAIT:
  - mul_a and mul_b are held unchanged.
  - On mul_done, register mul_q into vm_r and go to PVM_START.
- PVM_START:
  - mul_start=1, mul_a=proj_r, mul_b=vm_r.
  - Go to PVM_WAIT.
- PVM_WAIT:
  - Operands are held.
  - On mul_done, register mul_q into mvp and go to OUT.
- OUT:
  - out_valid=1; mvp is stable.
  - On out_ready, go to IDLE.
- Operand stability: mul_a and mul_b stay constant from each mul_start cycle through its mul_done cycle inclusive.
- mul_done outside VM_WAIT and PVM_WAIT is ignored and does not change state.
- Watchdog:
  - The counter clears on each mul_start.
  - It increments every cycle in VM_WAIT and PVM_WAIT.
  - If it reaches TIMEOUT without mul_done, err pulses for one cycle and the FSM returns to IDLE. The job is dropped and out_valid is not asserted.
  - The counter is wide enough for TIMEOUT; it never wraps.
- No arithmetic in this block. Operand and result widths are exactly mat4.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, mul_start=0, err=0; mul_a, mul_b, mvp and internal registers are all 0.
- Reset mid-job: the in-flight job is discarded. Any later mul_done is ignored because the FSM is in IDLE.
- Acceptance at cycle T (IDLE, in_valid=1): mul_start=1 at T+1.
- With multiplier latency L (mul_done arriving L cycles after mul_start, L≥1):
  - first mul_done at T+1+L;
  - second mul_start at T+2+L;
  - second mul_done at T+2+2L;
  - out_valid=1 from T+3+2L.
- Latency from acceptance to out_valid = 3+2L cycles.
- in_ready is 0 in every state except IDLE; there is one job in flight at most.
- out_valid stays high and mvp stays stable until out_ready.
- Handshake in OUT at cycle U: in_ready=1 at U+1. There is no same-cycle turnaround.
- out_ready while out_valid=0 has no effect.
- mul_done in the same cycle as the watchdog reaching TIMEOUT: done wins and err is not raised.
- TIMEOUT=0: err is never asserted, and the block waits indefinitely.

## Test plan
- Identity job, model multiplier with L=3: proj=view=model=I, accept at T -> mul_start at T+1 and T+5; out_valid at T+9; mvp=I; in_ready=1 at T+10 after out_ready.
- Ordering: proj=diag(2), view=translate(1,0,0), model=diag(3), L=1 -> first product observed with mul_a=view and mul_b=model. Result mvp = proj·view·model (translation column 2, diagonal 6).
- Backpressure: out_ready held 0 for 20 cycles after out_valid -> mvp stable, in_ready=0 throughout, no extra mul_start.
- Operand stability / spurious done: multiplier with L=7, and an extra mul_done injected while in OUT -> mul_a and mul_b are unchanged over the 7 cycles; the stray done is ignored.
- Watchdog: TIMEOUT=10, multiplier never responds -> err pulses exactly once, 10 cycles after mul_start; FSM is back in IDLE (in_ready=1); out_valid never asserts.
- Async reset asserted in VM_WAIT -> outputs are at their reset values immediately without a clock edge; a late mul_done after release is ignored; the next job completes correctly.
